pipeline_hazard_ctrl_ysyx_23060136: RTL

Central stall/flush controller for the 5-stage core. It drives the FORWARD_stall*/FORWARD_flush* inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB segment registers. It owns the data-memory request handshake FSM, load-use interlock, branch redirect flush, a memory timeout watchdog, and the sticky system-halt freeze. It also keeps stall and flush performance counters.

---
 rtl/pipeline_hazard_ctrl_ysyx_23060136.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl_ysyx_23060136.sv
// Central stall/flush controller: dmem handshake FSM, load-use interlock,
// redirect flush, memory watchdog, sticky halt and perf counters.
module pipeline_hazard_ctrl_ysyx_23060136 #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_write_gpr,
  input  logic             EX_mem_to_reg,
  input  logic             EX_redirect,
  input  logic             ME_mem_req,
  input  logic             dmem_req_ready,
  input  logic             dmem_resp_valid,
  input  logic             WB_system_halt,
  output logic             dmem_req_valid,
  output logic             FORWARD_stallIF,
  output logic             FORWARD_stallID,
  output logic             FORWARD_stallEX,
  output logic             FORWARD_stallME,
  output logic             FORWARD_stallWB,
  output logic             FORWARD_flushIF,
  output logic             FORWARD_flushID,
  output logic             FORWARD_flushEX,
  output logic             FORWARD_flushME,
  output logic             halted,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam int unsigned WDOG_W = 8;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wdog_inc;
  logic              freeze;
  logic              mem_busy;
  logic              load_use;
  logic              stall_any;
  logic              flush_take;

  assign freeze   = halted | dmem_timeout;
  assign mem_busy = ((state == IDLE) & ME_mem_req) | (state == REQ) |
                    ((state == WAIT) & ~dmem_resp_valid);
  assign load_use = EX_write_gpr & EX_mem_to_reg & (EX_rd != 5'd0) &
                    ((EX_rd == ID_rs1) | (EX_rd == ID_rs2));
  assign wdog_inc = wdog + WDOG_W'(1);

  // Stall counted only for real pipeline stalls, not the halt/timeout freeze.
  assign stall_any  = ~freeze & (mem_busy | (~EX_redirect & load_use));
  assign flush_take = ~freeze & ~mem_busy & EX_redirect;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next      = state;
    dmem_req_valid  = 1'b0;
    FORWARD_stallIF = 1'b0;
    FORWARD_stallID = 1'b0;
    FORWARD_stallEX = 1'b0;
    FORWARD_stallME = 1'b0;
    FORWARD_stallWB = 1'b0;
    FORWARD_flushIF = 1'b0;
    FORWARD_flushID = 1'b0;
    FORWARD_flushEX = 1'b0;
    FORWARD_flushME = 1'b0;
    if (!freeze) begin
      case (state)
        IDLE:    if (ME_mem_req) state_next = dmem_req_ready ? WAIT : REQ;
        REQ:     if (dmem_req_ready) state_next = WAIT;
        WAIT:    if (dmem_resp_valid) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
    if (!rst) begin
      dmem_req_valid = ~freeze & (((state == IDLE) & ME_mem_req) | (state == REQ));
      if (freeze) begin
        FORWARD_stallIF = 1'b1;
        FORWARD_stallID = 1'b1;
        FORWARD_stallEX = 1'b1;
        FORWARD_stallME = 1'b1;
        FORWARD_stallWB = 1'b1;
      end else if (mem_busy) begin
        // WB keeps draining; a bubble enters MEM/WB while MEM is held.
        FORWARD_stallIF = 1'b1;
        FORWARD_stallID = 1'b1;
        FORWARD_stallEX = 1'b1;
        FORWARD_stallME = 1'b1;
        FORWARD_flushME = 1'b1;
      end else if (EX_redirect) begin
        FORWARD_flushIF = 1'b1;
        FORWARD_flushID = 1'b1;
      end else if (load_use) begin
        FORWARD_stallIF = 1'b1;
        FORWARD_stallID = 1'b1;
        FORWARD_flushEX = 1'b1;
      end
    end
  end

  // Watchdog and sticky error/halt flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog         <= '0;
      dmem_timeout <= 1'b0;
      halted       <= 1'b0;
    end else begin
      if (WB_system_halt) halted <= 1'b1;
      if (!freeze && state == WAIT) begin
        if (dmem_resp_valid) begin
          wdog <= '0;
        end else begin
          wdog <= wdog_inc;
          if (wdog_inc == WDOG_W'(TIMEOUT)) dmem_timeout <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_any)  stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_take) flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule
